// File: rtl/tb_lifo_reorder.sv
// Segment reorder buffer behind the Viterbi traceback: captures newest-first bit
// segments into two ping-pong banks and replays each one oldest-first.
module tb_lifo_reorder #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic wr_en,
  input  logic d_in,
  output logic d_o,
  output logic valid_o,
  output logic seg_last_o,
  output logic err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {FREE, FILLING, PENDING, READING} bank_state_t;

  logic             mem [2][DEPTH];
  bank_state_t      state_reg  [2];
  bank_state_t      state_next [2];
  logic [CNT_W-1:0] len_reg    [2];
  logic [CNT_W-1:0] len_next   [2];
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic [AW-1:0]    idx_reg;
  logic             wb_reg;
  logic             rb_reg;
  logic             rd_busy_reg;

  logic wr_ok, wr_accept, wr_drop, close_full, close_fall;
  logic rd_pick, rd_start, rd_end, rd_chain;

  always_comb begin
    wr_ok      = (state_reg[wb_reg] == FREE) || (state_reg[wb_reg] == FILLING);
    wr_accept  = enable && wr_en && wr_ok;
    wr_drop    = enable && wr_en && !wr_ok;
    cnt_inc    = cnt_reg + CNT_W'(1);
    close_full = wr_accept && (cnt_inc == CNT_W'(DEPTH));
    close_fall = enable && !wr_en && (cnt_reg != '0);
    // If both banks wait, the one at wb_reg closed first and is older.
    rd_pick    = (state_reg[wb_reg] == PENDING) ? wb_reg : ~wb_reg;
    rd_start   = enable && !rd_busy_reg && (state_reg[rd_pick] == PENDING);
    rd_end     = enable && rd_busy_reg && (idx_reg == '0);
    rd_chain   = rd_end && (state_reg[~rb_reg] == PENDING);

    for (int b = 0; b < 2; b++) begin
      state_next[b] = state_reg[b];
      len_next[b]   = len_reg[b];
      if (!enable) begin
        state_next[b] = FREE;
      end else begin
        if (wb_reg == 1'(b)) begin
          if (close_full) begin
            state_next[b] = PENDING;
            len_next[b]   = cnt_inc;
          end else if (wr_accept) begin
            state_next[b] = FILLING;
          end else if (close_fall) begin
            state_next[b] = PENDING;
            len_next[b]   = cnt_reg;
          end
        end
        if (rd_start && (rd_pick == 1'(b))) state_next[b] = READING;
        if (rd_end && (rb_reg == 1'(b)))    state_next[b] = FREE;
        if (rd_chain && (rb_reg != 1'(b)))  state_next[b] = READING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wb_reg][cnt_reg[AW-1:0]] <= d_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        state_reg[b] <= FREE;
        len_reg[b]   <= '0;
      end
      cnt_reg     <= '0;
      idx_reg     <= '0;
      wb_reg      <= 1'b0;
      rb_reg      <= 1'b0;
      rd_busy_reg <= 1'b0;
      d_o         <= 1'b0;
      valid_o     <= 1'b0;
      seg_last_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_reg[b] <= state_next[b];
        len_reg[b]   <= len_next[b];
      end
      if (!enable) begin
        cnt_reg     <= '0;
        rd_busy_reg <= 1'b0;
        d_o         <= 1'b0;
        valid_o     <= 1'b0;
        seg_last_o  <= 1'b0;
      end else begin
        if (wr_drop) err_o <= 1'b1;

        if (close_full || close_fall) begin
          cnt_reg <= '0;
          wb_reg  <= ~wb_reg;
        end else if (wr_accept) begin
          cnt_reg <= cnt_inc;
        end

        if (rd_busy_reg) begin
          d_o        <= mem[rb_reg][idx_reg];
          valid_o    <= 1'b1;
          seg_last_o <= (idx_reg == '0);
          if (idx_reg == '0) begin
            // Hand straight over to the other bank so no bubble appears.
            if (rd_chain) begin
              rb_reg  <= ~rb_reg;
              idx_reg <= AW'(len_reg[~rb_reg] - CNT_W'(1));
            end else begin
              rd_busy_reg <= 1'b0;
            end
          end else begin
            idx_reg <= idx_reg - AW'(1);
          end
        end else begin
          d_o        <= 1'b0;
          valid_o    <= 1'b0;
          seg_last_o <= 1'b0;
          if (rd_start) begin
            rd_busy_reg <= 1'b1;
            rb_reg      <= rd_pick;
            idx_reg     <= AW'(len_reg[rd_pick] - CNT_W'(1));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tb_lifo_reorder.sv
// Directed bench for the segment reorder buffer with DEPTH=8; each task drives
// one scenario and checks the captured output stream against hand-derived values.
module tb_tb_lifo_reorder;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic wr_en = 1'b0;
  logic d_in = 1'b0;
  logic d_o, valid_o, seg_last_o, err_o;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic obs_d [$];
  logic obs_l [$];
  int   obs_t [$];

  tb_lifo_reorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .d_in(d_in),
    .d_o(d_o), .valid_o(valid_o), .seg_last_o(seg_last_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) begin
      obs_d.push_back(d_o);
      obs_l.push_back(seg_last_o);
      obs_t.push_back(cyc);
      $display("[TB] out cyc=%0d d_o=%0b seg_last=%0b err=%0b", cyc, d_o, seg_last_o, err_o);
    end
  end

  task automatic step(input logic en, input logic we, input logic d);
    enable = en;
    wr_en  = we;
    d_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_l.delete();
    obs_t.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({d_o, valid_o, seg_last_o, err_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got d/v/l/e=%b want 0000", {d_o, valid_o, seg_last_o, err_o});
    end
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_valid: got %b want 0", valid_o);
    end
  endtask

  task automatic test_full_segment();
    logic wr_bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    logic exp_d   [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    int close_cyc;
    clear_obs();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, wr_bits[i]);
    close_cyc = cyc;
    idle(13);
    tests_run++;
    if (obs_d.size() !== 8) begin
      tests_failed++;
      $display("FAIL full_count: got %0d bits want 8", obs_d.size());
    end
    for (int i = 0; i < 8 && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL full_bit%0d: got d=%b last=%b want d=%b last=%b", i, obs_d[i], obs_l[i], exp_d[i], i == 7);
      end
    end
    if (obs_t.size() == 8) begin
      tests_run++;
      if (obs_t[0] !== close_cyc + 2 || obs_t[7] !== obs_t[0] + 7) begin
        tests_failed++;
        $display("FAIL full_timing: got first=%0d last=%0d want first=%0d last=%0d", obs_t[0], obs_t[7], close_cyc + 2, close_cyc + 9);
      end
    end
    tests_run++;
    if (err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_err: got %b want 0", err_o);
    end
  endtask

  task automatic test_back_to_back();
    int close_cyc;
    clear_obs();
    close_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, i[0]);
      if (i == 7) close_cyc = cyc;
    end
    idle(14);
    tests_run++;
    if (obs_d.size() !== 16) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d bits want 16", obs_d.size());
    end
    for (int i = 0; i < 16 && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== ~i[0] || obs_l[i] !== (i == 7 || i == 15)) begin
        tests_failed++;
        $display("FAIL b2b_bit%0d: got d=%b last=%b want d=%b last=%b", i, obs_d[i], obs_l[i], ~i[0], (i == 7 || i == 15));
      end
    end
    if (obs_t.size() == 16) begin
      tests_run++;
      if (obs_t[0] !== close_cyc + 2 || obs_t[15] !== obs_t[0] + 15) begin
        tests_failed++;
        $display("FAIL b2b_timing: got first=%0d last=%0d want first=%0d last=%0d", obs_t[0], obs_t[15], close_cyc + 2, close_cyc + 17);
      end
    end
  endtask

  task automatic test_short_segment();
    logic exp_d [3] = '{0, 1, 1};
    int close_cyc;
    clear_obs();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    close_cyc = cyc;
    idle(6);
    tests_run++;
    if (obs_d.size() !== 3) begin
      tests_failed++;
      $display("FAIL short_count: got %0d bits want 3", obs_d.size());
    end
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 2)) begin
        tests_failed++;
        $display("FAIL short_bit%0d: got d=%b last=%b want d=%b last=%b", i, obs_d[i], obs_l[i], exp_d[i], i == 2);
      end
    end
    if (obs_t.size() > 0) begin
      tests_run++;
      if (obs_t[0] !== close_cyc + 2) begin
        tests_failed++;
        $display("FAIL short_latency: got cyc %0d want %0d", obs_t[0], close_cyc + 2);
      end
    end
  endtask

  task automatic test_overflow();
    logic wr_bits [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic exp_d   [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    clear_obs();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, wr_bits[i]);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_err_before: got %b want 0", err_o);
    end
    step(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_err_set: got %b want 1", err_o);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(10);
    tests_run++;
    if (obs_d.size() !== 9) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d bits want 9", obs_d.size());
    end
    for (int i = 0; i < 9 && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i >= 7)) begin
        tests_failed++;
        $display("FAIL ovf_bit%0d: got d=%b last=%b want d=%b last=%b", i, obs_d[i], obs_l[i], exp_d[i], i >= 7);
      end
    end
    if (obs_t.size() == 9) begin
      tests_run++;
      if (obs_t[8] !== obs_t[0] + 8) begin
        tests_failed++;
        $display("FAIL ovf_contiguous: got last cyc %0d want %0d", obs_t[8], obs_t[0] + 8);
      end
    end
    tests_run++;
    if (err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_err_sticky: got %b want 1", err_o);
    end
  endtask

  task automatic test_enable_abort();
    logic wr_bits [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    logic exp_a   [3] = '{1, 0, 0};
    logic exp_b   [3] = '{1, 0, 1};
    clear_obs();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, wr_bits[i]);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({d_o, valid_o, seg_last_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL en_abort_outputs: got d/v/l=%b want 000", {d_o, valid_o, seg_last_o});
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs_d.size() !== 3) begin
      tests_failed++;
      $display("FAIL en_abort_count: got %0d bits want 3", obs_d.size());
    end
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_a[i] || obs_l[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL en_abort_bit%0d: got d=%b last=%b want d=%b last=0", i, obs_d[i], obs_l[i], exp_a[i]);
      end
    end
    tests_run++;
    if (err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL en_err_hold: got %b want 1", err_o);
    end
    clear_obs();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(6);
    tests_run++;
    if (obs_d.size() !== 3) begin
      tests_failed++;
      $display("FAIL en_resume_count: got %0d bits want 3", obs_d.size());
    end
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_b[i] || obs_l[i] !== (i == 2)) begin
        tests_failed++;
        $display("FAIL en_resume_bit%0d: got d=%b last=%b want d=%b last=%b", i, obs_d[i], obs_l[i], exp_b[i], i == 2);
      end
    end
  endtask

  task automatic test_async_reset();
    logic wr_bits [5] = '{1, 0, 0, 1, 1};
    logic exp_d   [5] = '{1, 1, 0, 0, 1};
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests_run++;
    if ({d_o, valid_o} !== 2'b11) begin
      tests_failed++;
      $display("FAIL arst_pre_replay: got d/v=%b want 11", {d_o, valid_o});
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({d_o, valid_o, seg_last_o, err_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL arst_outputs: got d/v/l/e=%b want 0000", {d_o, valid_o, seg_last_o, err_o});
    end
    step(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    clear_obs();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, wr_bits[i]);
    step(1'b1, 1'b0, 1'b0);
    idle(8);
    tests_run++;
    if (obs_d.size() !== 5) begin
      tests_failed++;
      $display("FAIL arst_count: got %0d bits want 5", obs_d.size());
    end
    for (int i = 0; i < 5 && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 4)) begin
        tests_failed++;
        $display("FAIL arst_bit%0d: got d=%b last=%b want d=%b last=%b", i, obs_d[i], obs_l[i], exp_d[i], i == 4);
      end
    end
    tests_run++;
    if (err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_err: got %b want 0", err_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_segment();
    test_back_to_back();
    test_short_segment();
    test_overflow();
    test_enable_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
